akuma_anim_ctrl: RTL and testbench
==================================

Name: akuma_anim_ctrl

Overview:
Per-fighter animation sequencer for the Akuma sprite datapath. Arbitrates player requests (walk, punch, kick) and hit events into one pose. Steps animation frames on vertical-blank ticks and issues the registered sprite-sheet base address and facing select consumed by the sprite renderer. All visible outputs change only at frame boundaries, so a sprite never tears mid-scan.

Parameters:
IDLE_FRAMES, 4, frames in idle loop
WALK_FRAMES, 6, frames in walk loop
PUNCH_FRAMES, 4, frames in punch one-shot
KICK_FRAMES, 5, frames in kick one-shot
HOLD_TICKS, 4, frame_ticks each animation frame is held
HITSTUN_TICKS, 20, frame_ticks spent in hitstun
SPRITE_WORDS, 7800, ROM words per sprite frame (65x120)
ADDR_W, 18, rom_base width

Ports:
vga_clk  in  1  pixel clock; sole clock
reset_n  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse at start of vblank
move_left, move_right  in  1 each  level inputs from keyboard decode
punch_req, kick_req  in  1 each  one-cycle request pulses
hit_in  in  1  one-cycle pulse: fighter struck
self_x, opp_x  in  10 each  fighter x positions
pose  out  3  IDLE=0, WALK=1, PUNCH=2, KICK=3, HITSTUN=4
anim_frame  out  3  frame index within pose
rom_base  out  ADDR_W  sprite-sheet word offset of current frame
facing_right  out  1  1 = face right
attack_active  out  1  hitbox live
req_ack  out  1  one-cycle pulse when a punch/kick is accepted

Behaviour:
- Reset, asynchronous, active-low. All outputs and internal state clear to 0: pose=IDLE, anim_frame=0, rom_base=0, facing_right=0, attack_active=0, req_ack=0. Pending latches and counters also clear.
- Pending latches: punch_req, kick_req and hit_in each set a sticky bit in any cycle. The bits are consumed only at the next frame_tick. A pulse arriving in the same cycle as frame_tick counts for that tick.
- At each frame_tick, choose the next pose by priority: hit > kick > punch > walk > idle.
  - A pending hit enters HITSTUN from any state, including HITSTUN itself, where it restarts the count.
  - PUNCH and KICK can be interrupted only by a hit. Punch or kick requests pending during an attack are dropped at that tick, with no ack.
  - From IDLE/WALK, a pending kick or punch enters that pose and pulses req_ack for 1 cycle. If both are pending, kick wins and both latches clear.
  - Otherwise WALK if move_left XOR move_right, else IDLE.
- Entering a new pose resets anim_frame=0 and the hold counter.
- Animation stepping within a pose: the hold counter increments each tick. When it reaches HOLD_TICKS-1, it wraps to 0 and anim_frame advances.
  - IDLE and WALK loop modulo their frame count.
  - PUNCH/KICK: advancing past the last frame returns to IDLE, or to WALK if movement is held. anim_frame becomes 0.
  - HITSTUN: anim_frame stays 0. A separate counter runs HITSTUN_TICKS ticks, then the state goes to IDLE.
- attack_active=1 only on PUNCH frame 2 and KICK frames 2–3.
- facing_right: updated at frame_tick only while the next pose is IDLE or WALK, to (opp_x > self_x). Equal positions keep the previous value. The value is frozen during attacks and hitstun.
- rom_base = (POSE_BASE[pose] + anim_frame) * SPRITE_WORDS.
  - POSE_BASE offsets are 0, 4, 10, 14, 19 (the prefix sums of the frame counts).
  - Computed in ADDR_W bits, max (19)*7800 = 148200 < 2^18.
  - Registered.
- Latency: pose, anim_frame, facing_right and attack_active update on the vga_clk edge after frame_tick. rom_base updates one cycle later, before the first active line. Outputs are stable between ticks.
- No frame_tick: outputs hold indefinitely.

Decomposition:
- akuma_pkg holds:
  - the pose_t enum;
  - frame-count constants and the POSE_BASE offset function;
  - the SPRITE_WORDS localparam.
- One sub-module, akuma_anim_counter, holds the hold counter plus the frame counter. It takes a wrap/one-shot mode and a restart input, and outputs last-frame.

Test Plan:
1. Reset, then no inputs for 40 ticks → pose=0, anim_frame cycles 0,1,2,3 advancing every 4th tick; rom_base = anim_frame*7800.
2. move_right held with opp_x=300, self_x=100 → after the next tick pose=1 and facing_right=1. After 24 ticks anim_frame has wrapped 5→0; rom_base at frame 0 = 31200.
3. kick_req and punch_req in the same cycle from IDLE → one req_ack, pose=3. attack_active high for ticks 8–15 after entry. Returns to IDLE after 20 ticks.
4. punch_req while in KICK → no ack, no effect. hit_in during KICK frame 1 → pose=4 at next tick, rom_base=148200, IDLE after exactly 20 ticks.
5. hit_in in HITSTUN at tick 15 → counter restarts; 20 more ticks before IDLE.
6. reset_n asserted mid-PUNCH between clock edges → all outputs 0 immediately. After release, first tick gives pose=IDLE.

Source files
------------

// File: rtl/akuma_pkg.sv
// Shared pose encoding, frame-count constants and sprite-sheet layout helpers
// for the Akuma animation sequencer.
package akuma_pkg;

   typedef enum logic [2:0] {
      POSE_IDLE    = 3'd0,
      POSE_WALK    = 3'd1,
      POSE_PUNCH   = 3'd2,
      POSE_KICK    = 3'd3,
      POSE_HITSTUN = 3'd4
   } pose_t;

   localparam int FRAME_W      = 3;
   localparam int IDLE_FRAMES  = 4;
   localparam int WALK_FRAMES  = 6;
   localparam int PUNCH_FRAMES = 4;
   localparam int KICK_FRAMES  = 5;
   localparam int SPRITE_WORDS = 7800;

   function automatic logic [FRAME_W-1:0] pose_frames(input pose_t p);
      case (p)
         POSE_IDLE:  pose_frames = FRAME_W'(IDLE_FRAMES);
         POSE_WALK:  pose_frames = FRAME_W'(WALK_FRAMES);
         POSE_PUNCH: pose_frames = FRAME_W'(PUNCH_FRAMES);
         POSE_KICK:  pose_frames = FRAME_W'(KICK_FRAMES);
         default:    pose_frames = FRAME_W'(1);
      endcase
   endfunction

   // Poses are packed back to back on the sprite sheet, so each base is the
   // running sum of the frame counts of the poses before it.
   function automatic logic [4:0] pose_base(input pose_t p);
      case (p)
         POSE_IDLE:  pose_base = 5'd0;
         POSE_WALK:  pose_base = 5'(IDLE_FRAMES);
         POSE_PUNCH: pose_base = 5'(IDLE_FRAMES + WALK_FRAMES);
         POSE_KICK:  pose_base = 5'(IDLE_FRAMES + WALK_FRAMES + PUNCH_FRAMES);
         default:    pose_base = 5'(IDLE_FRAMES + WALK_FRAMES + PUNCH_FRAMES + KICK_FRAMES);
      endcase
   endfunction

endpackage

// File: rtl/akuma_anim_counter.sv
// Hold/frame counter for one animation pose: each frame is held for
// HOLD_TICKS steps, then the frame index advances or wraps.
module akuma_anim_counter
   import akuma_pkg::*;
#(
   parameter int HOLD_TICKS = 4
) (
   input  logic               vga_clk,
   input  logic               reset_n,
   input  logic               step,
   input  logic               restart,
   input  logic               one_shot,
   input  logic [FRAME_W-1:0] frame_count,
   output logic [FRAME_W-1:0] frame,
   output logic               last_frame
);

   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   logic [HW-1:0] hold;
   logic          hold_done;
   logic          at_end;

   assign hold_done  = (hold == HW'(HOLD_TICKS - 1));
   assign at_end     = (frame == frame_count - FRAME_W'(1));
   assign last_frame = hold_done && at_end;

   // One-shot poses park on their last frame; the owner restarts the
   // counter when it leaves the pose.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hold  <= '0;
         frame <= '0;
      end else if (step) begin
         if (restart) begin
            hold  <= '0;
            frame <= '0;
         end else if (hold_done) begin
            hold <= '0;
            if (at_end)
               frame <= one_shot ? frame : '0;
            else
               frame <= frame + FRAME_W'(1);
         end else begin
            hold <= hold + HW'(1);
         end
      end
   end

endmodule

// File: rtl/akuma_anim_ctrl.sv
// Per-fighter pose arbiter and frame sequencer; all outputs move only on
// frame_tick so the renderer never sees a pose change mid-scan.
module akuma_anim_ctrl
   import akuma_pkg::*;
#(
   parameter int HOLD_TICKS    = 4,
   parameter int HITSTUN_TICKS = 20,
   parameter int ADDR_W        = 18
) (
   input  logic              vga_clk,
   input  logic              reset_n,
   input  logic              frame_tick,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              punch_req,
   input  logic              kick_req,
   input  logic              hit_in,
   input  logic [9:0]        self_x,
   input  logic [9:0]        opp_x,
   output logic [2:0]        pose,
   output logic [2:0]        anim_frame,
   output logic [ADDR_W-1:0] rom_base,
   output logic              facing_right,
   output logic              attack_active,
   output logic              req_ack
);

   localparam int HSW = $clog2(HITSTUN_TICKS + 1);

   pose_t             pose_q;
   pose_t             next_pose;
   logic              pend_punch;
   logic              pend_kick;
   logic              pend_hit;
   logic              hit_p;
   logic              kick_p;
   logic              punch_p;
   logic              moving;
   logic              accept;
   logic              restart;
   logic              facing_next;
   logic              last_frame;
   logic [HSW-1:0]    hitstun_cnt;
   logic [ADDR_W-1:0] frame_index;

   assign hit_p   = pend_hit   | hit_in;
   assign kick_p  = pend_kick  | kick_req;
   assign punch_p = pend_punch | punch_req;
   assign moving  = move_left ^ move_right;
   assign pose    = pose_q;

   akuma_anim_counter #(
      .HOLD_TICKS (HOLD_TICKS)
   ) u_counter (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .step        (frame_tick),
      .restart     (restart),
      .one_shot    ((pose_q == POSE_PUNCH) || (pose_q == POSE_KICK)),
      .frame_count (pose_frames(pose_q)),
      .frame       (anim_frame),
      .last_frame  (last_frame)
   );

   // Requests are latched between ticks and all consumed together at a tick.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_punch <= 1'b0;
         pend_kick  <= 1'b0;
         pend_hit   <= 1'b0;
      end else if (frame_tick) begin
         pend_punch <= 1'b0;
         pend_kick  <= 1'b0;
         pend_hit   <= 1'b0;
      end else begin
         pend_punch <= punch_p;
         pend_kick  <= kick_p;
         pend_hit   <= hit_p;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pose_q       <= POSE_IDLE;
         facing_right <= 1'b0;
         hitstun_cnt  <= '0;
         req_ack      <= 1'b0;
      end else begin
         req_ack <= frame_tick && accept;
         if (frame_tick) begin
            pose_q       <= next_pose;
            facing_right <= facing_next;
            hitstun_cnt  <= (hit_p || (pose_q != POSE_HITSTUN)) ? '0 : hitstun_cnt + HSW'(1);
         end
      end
   end

   // Priority hit > kick > punch > walk > idle; attacks only yield to a hit.
   always_comb begin
      next_pose = pose_q;
      accept    = 1'b0;
      restart   = 1'b0;
      if (hit_p) begin
         next_pose = POSE_HITSTUN;
         restart   = 1'b1;
      end else begin
         case (pose_q)
            POSE_PUNCH, POSE_KICK: begin
               if (last_frame) begin
                  next_pose = moving ? POSE_WALK : POSE_IDLE;
                  restart   = 1'b1;
               end
            end
            POSE_HITSTUN: begin
               restart = 1'b1;
               if (hitstun_cnt == HSW'(HITSTUN_TICKS - 1))
                  next_pose = POSE_IDLE;
            end
            default: begin
               if (kick_p) begin
                  next_pose = POSE_KICK;
                  accept    = 1'b1;
               end else if (punch_p) begin
                  next_pose = POSE_PUNCH;
                  accept    = 1'b1;
               end else if (moving) begin
                  next_pose = POSE_WALK;
               end else begin
                  next_pose = POSE_IDLE;
               end
               restart = (next_pose != pose_q);
            end
         endcase
      end

      facing_next = facing_right;
      if ((next_pose == POSE_IDLE) || (next_pose == POSE_WALK)) begin
         if (opp_x > self_x)
            facing_next = 1'b1;
         else if (opp_x < self_x)
            facing_next = 1'b0;
      end
   end

   always_comb begin
      attack_active = 1'b0;
      if ((pose_q == POSE_PUNCH) && (anim_frame == 3'd2))
         attack_active = 1'b1;
      else if ((pose_q == POSE_KICK) && ((anim_frame == 3'd2) || (anim_frame == 3'd3)))
         attack_active = 1'b1;
   end

   // Address lags the pose by a cycle, still well before the first active line.
   assign frame_index = ADDR_W'(pose_base(pose_q)) + ADDR_W'(anim_frame);

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)
         rom_base <= '0;
      else
         rom_base <= frame_index * ADDR_W'(SPRITE_WORDS);
   end

endmodule

// File: tb/tb_akuma_anim_ctrl.sv
// Bench for akuma_anim_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a tick-count model of the animation rules.
module tb_akuma_anim_ctrl;

   localparam int HOLD    = 4;
   localparam int HITSTUN = 20;
   localparam int WORDS   = 7800;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        frame_tick = 1'b0;
   logic        move_left = 1'b0;
   logic        move_right = 1'b0;
   logic        punch_req = 1'b0;
   logic        kick_req = 1'b0;
   logic        hit_in = 1'b0;
   logic [9:0]  self_x = 10'd0;
   logic [9:0]  opp_x = 10'd0;
   logic [2:0]  pose;
   logic [2:0]  anim_frame;
   logic [17:0] rom_base;
   logic        facing_right;
   logic        attack_active;
   logic        req_ack;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_cnt = 0;
   logic chk_en = 1'b0;

   int   m_pose = 0;
   int   m_k = 0;
   logic m_face = 1'b0;
   logic m_pp = 1'b0, m_pk = 1'b0, m_ph = 1'b0;
   int   exp_rom = 0;
   logic exp_ack = 1'b0;

   akuma_anim_ctrl dut (
      .vga_clk       (vga_clk),
      .reset_n       (reset_n),
      .frame_tick    (frame_tick),
      .move_left     (move_left),
      .move_right    (move_right),
      .punch_req     (punch_req),
      .kick_req      (kick_req),
      .hit_in        (hit_in),
      .self_x        (self_x),
      .opp_x         (opp_x),
      .pose          (pose),
      .anim_frame    (anim_frame),
      .rom_base      (rom_base),
      .facing_right  (facing_right),
      .attack_active (attack_active),
      .req_ack       (req_ack)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic int frames_of(input int p);
      case (p)
         0:       return 4;
         1:       return 6;
         2:       return 4;
         3:       return 5;
         default: return 1;
      endcase
   endfunction

   function automatic int base_of(input int p);
      int s = 0;
      for (int q = 0; q < p; q++) s += frames_of(q);
      return s;
   endfunction

   // Frame index derived purely from ticks elapsed since the pose was entered.
   function automatic int frame_of(input int p, input int k);
      if (p == 4) return 0;
      if (p >= 2) return k / HOLD;
      return (k / HOLD) % frames_of(p);
   endfunction

   function automatic logic attack_of(input int p, input int k);
      int f = frame_of(p, k);
      return (p == 2 && f == 2) || (p == 3 && (f == 2 || f == 3));
   endfunction

   always @(posedge vga_clk or negedge reset_n) begin
      logic hp, kp, pp, mv;
      int   tgt;
      if (!reset_n) begin
         m_pose = 0; m_k = 0; m_face = 1'b0;
         m_pp = 1'b0; m_pk = 1'b0; m_ph = 1'b0;
         exp_rom = 0; exp_ack = 1'b0;
      end else begin
         exp_rom = (base_of(m_pose) + frame_of(m_pose, m_k)) * WORDS;
         exp_ack = 1'b0;
         hp = m_ph | hit_in;
         kp = m_pk | kick_req;
         pp = m_pp | punch_req;
         mv = move_left ^ move_right;
         if (frame_tick) begin
            if (hp) begin
               m_pose = 4; m_k = 0;
            end else if (m_pose == 2 || m_pose == 3) begin
               if (m_k + 1 == frames_of(m_pose) * HOLD) begin
                  m_pose = mv ? 1 : 0; m_k = 0;
               end else m_k++;
            end else if (m_pose == 4) begin
               if (m_k + 1 == HITSTUN) begin
                  m_pose = 0; m_k = 0;
               end else m_k++;
            end else begin
               tgt = kp ? 3 : (pp ? 2 : (mv ? 1 : 0));
               exp_ack = kp | pp;
               if (tgt == m_pose) m_k++;
               else begin
                  m_pose = tgt; m_k = 0;
               end
            end
            if (m_pose <= 1) begin
               if (opp_x > self_x) m_face = 1'b1;
               else if (opp_x < self_x) m_face = 1'b0;
            end
            m_pp = 1'b0; m_pk = 1'b0; m_ph = 1'b0;
         end else begin
            m_pp = pp; m_pk = kp; m_ph = hp;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge vga_clk) begin
      if (req_ack === 1'b1) ack_cnt++;
      if (chk_en) begin
         checkOutput("pose",          32'(pose),          32'(m_pose));
         checkOutput("anim_frame",    32'(anim_frame),    32'(frame_of(m_pose, m_k)));
         checkOutput("rom_base",      32'(rom_base),      32'(exp_rom));
         checkOutput("facing_right",  32'(facing_right),  32'(m_face));
         checkOutput("attack_active", 32'(attack_active), 32'(attack_of(m_pose, m_k)));
         checkOutput("req_ack",       32'(req_ack),       32'(exp_ack));
      end
   end

   task automatic applyStimulus(input logic tk, input logic pr, input logic kr, input logic hi);
      @(posedge vga_clk);
      #1;
      frame_tick = tk;
      punch_req  = pr;
      kick_req   = kr;
      hit_in     = hi;
   endtask

   task automatic tickN(input int n);
      repeat (n) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int ack_base;
      int att_ticks;
      int first_att;

      #1 reset_n = 1'b0;
      #1 chk_en = 1'b1;
      #2;
      checkOutput("reset_pose", 32'(pose), 0);
      checkOutput("reset_rom", 32'(rom_base), 0);
      #20 reset_n = 1'b1;

      // Idle loop: 40 ticks leaves frame 10 mod 4 = 2.
      tickN(40);
      checkOutput("idle_frame", 32'(anim_frame), 2);
      checkOutput("idle_rom", 32'(rom_base), 15600);

      self_x = 10'd100;
      opp_x  = 10'd300;
      move_right = 1'b1;
      tickN(1);
      checkOutput("walk_pose", 32'(pose), 1);
      checkOutput("walk_face", 32'(facing_right), 1);
      tickN(23);
      checkOutput("walk_frame5", 32'(anim_frame), 5);
      tickN(1);
      checkOutput("walk_wrap", 32'(anim_frame), 0);
      checkOutput("walk_rom0", 32'(rom_base), 31200);
      move_right = 1'b0;
      tickN(1);
      checkOutput("back_idle", 32'(pose), 0);

      // Kick and punch together: kick wins, single ack.
      ack_base = ack_cnt;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      tickN(1);
      checkOutput("kick_pose", 32'(pose), 3);
      checkOutput("kick_acks", 32'(ack_cnt - ack_base), 1);
      att_ticks = 0;
      first_att = -1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tickN(1);
         if (attack_active === 1'b1) begin
            att_ticks++;
            if (first_att < 0) first_att = k;
         end
      end
      checkOutput("kick_att_ticks", 32'(att_ticks), 8);
      checkOutput("kick_att_first", 32'(first_att), 8);
      tickN(1);
      checkOutput("kick_done", 32'(pose), 0);

      // Punch during kick is dropped; hit during kick frame 1 wins.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tickN(5);
      ack_base = ack_cnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tickN(1);
      checkOutput("kick_no_ack", 32'(ack_cnt - ack_base), 0);
      checkOutput("kick_frame1", 32'(anim_frame), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tickN(1);
      checkOutput("hit_pose", 32'(pose), 4);
      checkOutput("hit_rom", 32'(rom_base), 148200);
      tickN(19);
      checkOutput("hit_held", 32'(pose), 4);
      tickN(1);
      checkOutput("hit_exit", 32'(pose), 0);

      // Re-hit at tick 15 restarts the full stun.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tickN(1);
      tickN(15);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tickN(1);
      tickN(19);
      checkOutput("rehit_held", 32'(pose), 4);
      tickN(1);
      checkOutput("rehit_exit", 32'(pose), 0);

      // Asynchronous reset in the middle of a punch.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      tickN(3);
      checkOutput("punch_pose", 32'(pose), 2);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("arst_pose", 32'(pose), 0);
      checkOutput("arst_frame", 32'(anim_frame), 0);
      checkOutput("arst_rom", 32'(rom_base), 0);
      checkOutput("arst_face", 32'(facing_right), 0);
      checkOutput("arst_att", 32'({attack_active, req_ack}), 0);
      #4 reset_n = 1'b1;
      tickN(1);
      checkOutput("arst_first_tick", 32'(pose), 0);

      for (int t = 0; t < 1500; t++) begin
         logic tk, pr, kr, hi;
         tk = ($urandom_range(0, 3) == 0);
         pr = ($urandom_range(0, 19) == 0);
         kr = ($urandom_range(0, 24) == 0);
         hi = ($urandom_range(0, 149) == 0);
         applyStimulus(tk, pr, kr, hi);
         if ($urandom_range(0, 19) == 0) {move_left, move_right} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 15) == 0) begin
            self_x = 10'($urandom_range(0, 1023));
            opp_x  = ($urandom_range(0, 3) == 0) ? self_x : 10'($urandom_range(0, 1023));
         end
      end
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
